// File: rtl/ipml_prefetch_fifo_pkg.sv
// Shared definitions for the v2 prefetch FIFO.
//   OUT_DEPTH  : number of entries in the register output stage after the RAM
//   OUT_CNT_W  : width of the output-stage occupancy counter
//   clog2()    : ceiling log2 for elaboration-time sizing
//   lvl_w()    : fill-level width for a given RAM address width (ADDR_W+2)
//   lvl_flag() : level-versus-threshold compare used for almost_full/almost_empty
package ipml_prefetch_fifo_pkg;

  localparam int unsigned OUT_DEPTH = 2;

  typedef enum logic [0:0] {
    FLAG_GE = 1'b0,
    FLAG_LE = 1'b1
  } flag_cmp_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned OUT_CNT_W = clog2(OUT_DEPTH + 1);

  function automatic int unsigned lvl_w(input int unsigned addr_w);
    return addr_w + 2;
  endfunction

  function automatic logic lvl_flag(input flag_cmp_e kind, input int unsigned lvl,
                                    input int unsigned thr);
    return (kind == FLAG_GE) ? (lvl >= thr) : (lvl <= thr);
  endfunction

endpackage

// File: rtl/ipml_prefetch_fifo_sync_v2_0_out_stage.sv
// Two-entry register FIFO placed behind the RAM read port.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of occupancy (data registers hold)
//   in_vld      : load in_data this cycle (caller guarantees a free slot)
//   in_data     : word arriving from the RAM read register
//   out_rdy     : pop request; ignored while out_vld=0
//   out_data    : head word (holds when nothing is popped)
//   out_vld     : head word present
//   cnt         : occupancy 0..2
module ipml_prefetch_out_stage
  import ipml_prefetch_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_vld,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 out_rdy,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_vld,
  output logic [OUT_CNT_W-1:0] cnt
);

  logic [DATA_W-1:0]    head_q, head_d;
  logic [DATA_W-1:0]    tail_q, tail_d;
  logic [OUT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 pop;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    pop    = out_rdy & (cnt_q != '0);
    if (clr) begin
      cnt_d = '0;
    end else begin
      unique case ({in_vld, pop})
        2'b10: begin
          if (cnt_q == '0) head_d = in_data;
          else             tail_d = in_data;
          cnt_d = cnt_q + OUT_CNT_W'(1);
        end
        2'b01: begin
          // Shift only when a second word exists so the last popped word
          // stays visible on out_data.
          if (cnt_q == OUT_CNT_W'(2)) head_d = tail_q;
          cnt_d = cnt_q - OUT_CNT_W'(1);
        end
        2'b11: begin
          if (cnt_q == OUT_CNT_W'(1)) begin
            head_d = in_data;
          end else begin
            head_d = tail_q;
            tail_d = in_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_data = head_q;
  assign out_vld  = (cnt_q != '0);
  assign cnt      = cnt_q;

endmodule

// File: rtl/ipml_prefetch_fifo_sync_v2_0.sv
// Single-clock first-word-fall-through FIFO: 2^ADDR_W-word RAM with a
// one-cycle registered read, followed by a 2-entry prefetch stage.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : synchronous clear of all contents (wins over wr/rd)
//   wr_data, wr_en : write port; accepted when wr_en & wr_vld
//   wr_vld         : RAM has space
//   rd_data        : head word, valid while rd_vld
//   rd_en          : pop request; pop = rd_en & rd_vld
//   level          : words accepted and not yet popped (0..2^ADDR_W+2)
//   almost_full    : level >= AF_LEVEL (registered)
//   almost_empty   : level <= AE_LEVEL (registered)
//   overflow       : sticky wr_en while wr_vld=0
//   underflow      : sticky rd_en while rd_vld=0
// Build option: define IPML_PREFETCH_FIFO_ERR_FLAGS_EN to build the sticky
// error flags; otherwise overflow/underflow are tied low.
module ipml_prefetch_fifo_sync_v2_0
  import ipml_prefetch_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned AF_LEVEL = 1 << ADDR_W,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              wr_vld,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_en,
  output logic              rd_vld,
  output logic [ADDR_W+1:0] level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LVL_W = lvl_w(ADDR_W);

  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      ram_cnt_q, ram_cnt_d;
  logic                 inflight_q, inflight_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 af_q, ae_q;
  logic                 wr_acc, pop, rd_issue;
  logic [OUT_CNT_W-1:0] out_cnt;

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [DATA_W-1:0]    ram_rdata_q;

  // RAM count never exceeds DEPTH, so its MSB alone marks "full".
  assign wr_vld = ~ram_cnt_q[ADDR_W];

  always_comb begin
    wr_acc   = wr_en & wr_vld & ~flush;
    pop      = rd_en & rd_vld & ~flush;
    // Issue only if the word fits once everything already committed to the
    // output stage (resident + in flight, minus this cycle's pop) lands.
    rd_issue = (ram_cnt_q != '0) & ~flush &
               ((3'(out_cnt) + 3'(inflight_q) - 3'(pop)) < 3'(OUT_DEPTH));

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = 1'b0;
    level_d    = level_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      level_d   = '0;
    end else begin
      if (wr_acc)   wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_issue) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      ram_cnt_d  = ram_cnt_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_issue);
      inflight_d = rd_issue;
      level_d    = level_q + LVL_W'(wr_acc) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      level_q    <= '0;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
      af_q       <= lvl_flag(FLAG_GE, 32'(level_d), AF_LEVEL);
      ae_q       <= lvl_flag(FLAG_LE, 32'(level_d), AE_LEVEL);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)   mem_q[wr_ptr_q] <= wr_data;
    if (rd_issue) ram_rdata_q     <= mem_q[rd_ptr_q];
  end

  // flush also clears the stage, which drops any read still in flight.
  ipml_prefetch_out_stage #(
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .in_vld   (inflight_q),
    .in_data  (ram_rdata_q),
    .out_rdy  (rd_en),
    .out_data (rd_data),
    .out_vld  (rd_vld),
    .cnt      (out_cnt)
  );

  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

`ifdef IPML_PREFETCH_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en & ~wr_vld) ovf_q <= 1'b1;
      if (rd_en & ~rd_vld) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
